// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types for the main-RAM arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_I = 2'd1,
    LOCK_D = 2'd2
  } arb_state_t;

  localparam int WORD_W = 32;
  typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/arb_fairness_counter.sv
// rtl/arb_fairness_counter.sv - counts data wins over a pending fetch, raises force_i at STARVE_MAX
module arb_fairness_counter #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic ireq,
  input  logic done_i,
  input  logic done_d,
  output logic force_i
);

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  logic [3:0] scnt;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      scnt <= '0;
    end else if (!ireq || done_i) begin
      scnt <= '0;
    end else if (done_d && scnt != SMAX) begin
      scnt <= scnt + 4'd1;
    end
  end

  assign force_i = ireq && (scnt == SMAX);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter for the single-ported main RAM
// Optional MEM_ARB_STATS_EN adds completion and starvation-override counters.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int ADDR_W     = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [ADDR_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [ADDR_W-1:0] dstore,
  output logic              dwait,
  output logic [ADDR_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [ADDR_W-1:0] ramstore,
  input  logic [ADDR_W-1:0] ramload,
  input  logic [1:0]        ramstate
`ifdef MEM_ARB_STATS_EN
  ,
  output word_t             igrant_cnt,
  output word_t             dgrant_cnt,
  output word_t             starve_cnt
`endif
);

  ramstate_t  rs;
  arb_state_t state, state_next;
  logic dreq, force_i, grant_i, grant_d, done_i, done_d, hold;

  assign rs     = ramstate_t'(ramstate);
  assign dreq   = dREN | dWEN;
  assign done_i = grant_i && (rs == ACCESS);
  assign done_d = grant_d && (rs == ACCESS);
  assign hold   = (rs == FREE) || (rs == BUSY);

  arb_fairness_counter #(.STARVE_MAX(STARVE_MAX)) u_fair (
    .clk     (CLK),
    .resetn  (nRST),
    .ireq    (iREN),
    .done_i  (done_i),
    .done_d  (done_d),
    .force_i (force_i)
  );

  always_ff @(posedge CLK) begin
    if (!nRST) state <= IDLE;
    else       state <= state_next;
  end

  // In a LOCK state the grant simply follows the owner's request, so one rule covers every state.
  always_comb begin
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    state_next = IDLE;
    case (state)
      IDLE: begin
        grant_d = dreq && !force_i;
        grant_i = !grant_d && iREN;
      end
      LOCK_I:  grant_i = iREN;
      LOCK_D:  grant_d = dreq;
      default: ;
    endcase
    if (grant_d && hold)      state_next = LOCK_D;
    else if (grant_i && hold) state_next = LOCK_I;
  end

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    if (nRST) begin
      if (grant_d) begin
        ramREN   = dREN & ~dWEN;
        ramWEN   = dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
      end else if (grant_i) begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
      end
    end
  end

  assign iwait = !nRST || (iREN && !done_i);
  assign dwait = !nRST || (dreq && !done_d);
  assign iload = ramload;
  assign dload = ramload;

`ifdef MEM_ARB_STATS_EN
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      igrant_cnt <= '0;
      dgrant_cnt <= '0;
      starve_cnt <= '0;
    end else begin
      if (done_i) igrant_cnt <= igrant_cnt + 32'd1;
      if (done_d) dgrant_cnt <= dgrant_cnt + 32'd1;
      if (state == IDLE && force_i && dreq) starve_cnt <= starve_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized scoreboard bench for mem_arbiter
module tb_mem_arbiter;

  localparam int SM = 4;

  logic        CLK = 1'b0;
  logic        nRST, iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        iwait, dwait, ramREN, ramWEN;
  logic [31:0] iload, dload, ramaddr, ramstore;
`ifdef MEM_ARB_STATS_EN
  logic [31:0] igrant_cnt, dgrant_cnt, starve_cnt;
`endif

  mem_arbiter #(.STARVE_MAX(SM), .ADDR_W(32)) dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
`ifdef MEM_ARB_STATS_EN
    , .igrant_cnt(igrant_cnt), .dgrant_cnt(dgrant_cnt), .starve_cnt(starve_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        ren, wen, iw, dw, di, dd;
    logic [31:0] addr, store, load;
  } exp_t;

  exp_t  q[$];
  int    total = 0;
  int    bad = 0;
  int    owner = 0;   // 0 none, 1 fetch, 2 data
  int    fair = 0;    // data completions since the pending fetch was last served
  bit    capture = 0;
  string pat = "";

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%b required=%b", nm, act, req);
    end
  endtask

  // Drive one cycle and push the reference model's expected outputs for it.
  task automatic cyc(input bit rn, input bit ir, input bit dr, input bit dw,
                     input logic [31:0] ia, input logic [31:0] da, input logic [31:0] ds,
                     input logic [1:0] rs, input logic [31:0] rl,
                     output bit di, output bit dd);
    exp_t e;
    int   g;
    bit   dq, done;
    @(posedge CLK);
    #1;
    nRST = rn; iREN = ir; dREN = dr; dWEN = dw;
    iaddr = ia; daddr = da; dstore = ds; ramstate = rs; ramload = rl;
    e.ren = 0; e.wen = 0; e.addr = 0; e.store = 0; e.load = rl;
    e.iw = 1; e.dw = 1; e.di = 0; e.dd = 0;
    di = 0; dd = 0;
    if (!rn) begin
      owner = 0;
      fair = 0;
    end else begin
      dq = dr | dw;
      if (owner == 0) g = (dq && !(ir && fair == SM)) ? 2 : (ir ? 1 : 0);
      else if (owner == 1) g = ir ? 1 : 0;
      else g = dq ? 2 : 0;
      done = (g != 0) && (rs == 2'd2);
      if (g == 2) begin
        e.ren = dr & ~dw; e.wen = dw; e.addr = da; e.store = ds;
      end else if (g == 1) begin
        e.ren = 1; e.addr = ia;
      end
      di = done && g == 1;
      dd = done && g == 2;
      e.iw = ir && !di;
      e.dw = dq && !dd;
      e.di = di;
      e.dd = dd;
      owner = (g != 0 && rs <= 2'd1) ? g : 0;
      if (!ir || di) fair = 0;
      else if (dd && fair < SM) fair++;
    end
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk1("ramREN", ramREN, e.ren);
        chk1("ramWEN", ramWEN, e.wen);
        chk32("ramaddr", ramaddr, e.addr);
        chk32("ramstore", ramstore, e.store);
        chk1("iwait", iwait, e.iw);
        chk1("dwait", dwait, e.dw);
        if (e.di) chk32("iload", iload, e.load);
        if (e.dd) chk32("dload", dload, e.load);
        if (capture) begin
          if (!iwait && iREN) pat = {pat, "I"};
          else if (!dwait && (dREN | dWEN)) pat = {pat, "D"};
        end
      end
    end
  end

  initial begin : stim
    bit          a, b, ir, dr, dw, rn;
    logic [31:0] ia, da, ds;
    logic [1:0]  rs;
    int          r;
    nRST = 0; iREN = 0; dREN = 0; dWEN = 0;
    iaddr = 0; daddr = 0; dstore = 0; ramload = 0; ramstate = 0;

    // reset with both requesting, then data wins first after release
    cyc(0, 1, 1, 0, 32'h40, 32'h200, 0, 2'd2, 32'h1111, a, b);
    cyc(0, 1, 1, 0, 32'h40, 32'h200, 0, 2'd2, 32'h1111, a, b);
    cyc(1, 1, 1, 0, 32'h40, 32'h200, 0, 2'd2, 32'h2222, a, b);
    cyc(1, 0, 0, 0, 0, 0, 0, 2'd0, 0, a, b);

    // zero-wait fetch
    cyc(1, 1, 0, 0, 32'h40, 0, 0, 2'd2, 32'h8C220004, a, b);

    // locked data write, fetch waits
    for (int i = 0; i < 3; i++)
      cyc(1, 1, 0, 1, 32'h40, 32'h100, 32'hDEADBEEF, 2'd1, 0, a, b);
    cyc(1, 1, 0, 1, 32'h40, 32'h100, 32'hDEADBEEF, 2'd2, 32'h3333, a, b);
    cyc(1, 1, 0, 0, 32'h40, 0, 0, 2'd2, 32'h4444, a, b);
    cyc(1, 0, 0, 0, 0, 0, 0, 2'd0, 0, a, b);

    // starvation override
    capture = 1;
    for (int i = 0; i < 10; i++)
      cyc(1, 1, 1, 0, 32'h80 + 32'(i * 4), 32'h400 + 32'(i * 4), 0, 2'd2, $urandom(), a, b);
    @(negedge CLK);
    #1;
    capture = 0;
    total++;
    if (pat != "DDDDIDDDDI") begin
      bad++;
      $display("FAIL starve_pattern actual=%s required=DDDDIDDDDI", pat);
    end
    cyc(1, 0, 0, 0, 0, 0, 0, 2'd0, 0, a, b);

    // owner drops mid-lock, pending fetch then served
    cyc(1, 0, 1, 0, 32'h44, 32'h300, 0, 2'd1, 0, a, b);
    cyc(1, 1, 0, 0, 32'h44, 32'h300, 0, 2'd1, 0, a, b);
    cyc(1, 1, 0, 0, 32'h44, 0, 0, 2'd2, 32'h5555, a, b);

    // error retry on data read
    cyc(1, 0, 1, 0, 0, 32'h300, 0, 2'd3, 0, a, b);
    cyc(1, 0, 1, 0, 0, 32'h300, 0, 2'd2, 32'h6666, a, b);

    // randomized traffic; requesters hold until the model says they completed
    ir = 0; dr = 0; dw = 0; ia = 0; da = 0; ds = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!ir && $urandom_range(0, 2) == 0) begin
        ir = 1;
        ia = $urandom() & 32'hFFFF_FFFC;
      end
      if (!dr && !dw && $urandom_range(0, 2) == 0) begin
        r = $urandom_range(0, 4);
        dr = (r < 2) || (r == 4);
        dw = (r >= 2);
        da = $urandom() & 32'hFFFF_FFFC;
        ds = $urandom();
      end
      if ($urandom_range(0, 24) == 0) ir = 0;
      if ($urandom_range(0, 24) == 0) begin
        dr = 0;
        dw = 0;
      end
      r  = $urandom_range(0, 19);
      rs = (r < 9) ? 2'd2 : (r < 14) ? 2'd1 : (r < 16) ? 2'd0 : 2'd3;
      rn = ($urandom_range(0, 299) != 0);
      cyc(rn, ir, dr, dw, ia, da, ds, rs, $urandom(), a, b);
      if (a) ir = 0;
      if (b) begin
        dr = 0;
        dw = 0;
      end
    end

    cyc(1, 0, 0, 0, 0, 0, 0, 2'd0, 0, a, b);
    @(negedge CLK);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain actual=%0d required=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates the single-ported main RAM between the instruction-fetch path and the data-access path of the pipelined core.
- Sits between the datapath-side cache interfaces and the RAM model.
- Holds a granted requester until RAM signals ACCESS, and uses a starvation counter so fetches keep flowing under a long run of loads and stores.

Parameters:
- STARVE_MAX, 4: number of consecutive data grants allowed while a fetch is pending before the fetch is forced to win. Legal range 1..15.
- ADDR_W, 32: address and data width in bits.

Ports:
- CLK  in  1  system clock
- nRST  in  1  synchronous active-low reset
- iREN  in  1  instruction read request
- iaddr  in  ADDR_W  instruction byte address
- iwait  out  1  1 = instruction request not yet complete
- iload  out  ADDR_W  instruction read data
- dREN  in  1  data read request
- dWEN  in  1  data write request
- daddr  in  ADDR_W  data byte address
- dstore  in  ADDR_W  data write value
- dwait  out  1  1 = data request not yet complete
- dload  out  ADDR_W  data read data
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  ADDR_W  RAM address
- ramstore  out  ADDR_W  RAM write data
- ramload  in  ADDR_W  RAM read data
- ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3

Behaviour:
- Clocking and reset: one clock, CLK. Reset nRST is synchronous and active-low, sampled on the rising edge.
- Reset values:
  - Registers: state=IDLE, scnt=0.
  - Outputs while nRST is sampled low: ramREN=0, ramWEN=0, iwait=1, dwait=1, ramaddr=0, ramstore=0.
- States: IDLE, LOCK_I, LOCK_D.
- IDLE winner selection (combinational):
  - D wins if (dREN|dWEN) and !(iREN && scnt==STARVE_MAX).
  - Otherwise I wins if iREN.
  - Otherwise there is no winner and all RAM enables are 0.
- RAM drive:
  - The winner (IDLE) or owner (LOCK) drives ramaddr, and ramstore for data.
  - Data: ramWEN=dWEN. ramREN=dREN&!dWEN, so write has priority when both are set.
  - Instruction: ramREN=1, ramWEN=0.
- Completion:
  - The granted requester's wait goes to 0 in the same cycle ramstate==ACCESS.
  - iload/dload = ramload combinationally in that cycle.
  - The non-granted wait is always 1 whenever that requester is requesting.
- Transitions:
  - IDLE, winner present, ramstate!=ACCESS: go to LOCK_I or LOCK_D.
  - IDLE, winner present, ramstate==ACCESS: stay IDLE. This is the zero-wait path, with latency 1 cycle.
  - LOCK_x, ramstate==ACCESS: go to IDLE. Grant is held in LOCK regardless of the other requester.
  - LOCK_x, owner drops its request: the RAM enables go to 0 that cycle and the next state is IDLE. No completion is signalled.
  - ramstate==ERROR: treat as not complete, so wait stays 1. Go to IDLE so the request is re-arbitrated.
- Starvation counter (scnt):
  - Data completion with iREN=1: scnt+1, saturating at STARVE_MAX.
  - Instruction completion, or iREN=0 in any cycle: scnt=0.
- Wait outputs when idle: iwait=0 when iREN=0; dwait=0 when dREN|dWEN=0.
- Minimum throughput: a back-to-back data stream can block fetch for at most STARVE_MAX transactions.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- When defined, adds three outputs, each 32-bit and wrapping at 2^32:
  - igrant_cnt: instruction completions.
  - dgrant_cnt: data completions.
  - starve_cnt: number of times the starvation override forced an instruction win.
- All three counters are reset to 0 by nRST.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Shared package mem_arb_pkg holds:
  - ramstate_t enum (FREE/BUSY/ACCESS/ERROR, 2-bit).
  - arb_state_t enum (IDLE/LOCK_I/LOCK_D).
  - word_t.
- One natural sub-module: arb_fairness_counter, holding scnt with its saturate/clear rules and STARVE_MAX compare, and exporting force_i.

Test Plan:
- Reset: hold nRST=0 for 2 cycles with iREN=dREN=1 -> ramREN=ramWEN=0, iwait=dwait=1. After release, a data read is issued first.
- Zero-wait fetch: iREN=1, iaddr=0x40, ramstate=ACCESS, ramload=0x8C220004 -> same cycle ramaddr=0x40, iwait=0, iload=0x8C220004, state stays IDLE.
- Locked wait: dWEN=1, daddr=0x100, dstore=0xDEADBEEF, ramstate BUSY for 3 cycles then ACCESS, iREN=1 throughout.
  - RAM outputs are data for all 4 cycles and dwait=0 only in cycle 4.
  - The fetch is granted in cycle 5.
- Starvation: STARVE_MAX=4, iREN and dREN held high, every access zero-wait -> grant pattern D,D,D,D,I,D,D,D,D,I.
- Drop mid-lock: dREN in LOCK_D deasserts while BUSY -> ramREN=0 that cycle, state IDLE next. Pending iREN is then granted.
- Error retry: ramstate=ERROR during a data read -> dwait stays 1, state returns to IDLE, and the request re-issues with the same daddr.
